breakpoint_unit: RTL and testbench
==================================

// Module: breakpoint_unit
// PURPOSE
//  Parametrised multi-channel breakpoint/watchpoint unit; successor to the single break interface.
//  Sits between CPU buses and clock interface: samples PC and data-bus events per CPU cycle.
//  Drives oBreak to freeze the CPU clock on a qualified hit. Supports address masks, hit counts and single-step.
// PARAMETERS
//  N_BP    4   number of independent comparator channels (1..16)
//  ADDR_W  64  width of PC / data address compared
//  CNT_W   8   width of per-channel hit-count (skip) counter
// PORTS
//  iCLK        in   1          single clock (50MHz domain)
//  iRST        in   1          synchronous, active-high reset
//  iEvValid    in   1          one-cycle pulse per retired CPU cycle; qualifies the event inputs below
//  iPC         in   ADDR_W     PC of the event
//  iDAddress   in   ADDR_W     data-bus address
//  iDReadEn    in   1          data read this event
//  iDWriteEn   in   1          data write this event
//  iCfgWe      in   1          config write strobe
//  iCfgIdx     in   4          channel written (ignored if >= N_BP)
//  iCfgMode    in   2          00 off, 01 PC exec, 10 data read, 11 data write
//  iCfgAddr    in   ADDR_W     compare address
//  iCfgMask    in   ADDR_W     compare mask (1 = bit compared)
//  iCfgCount   in   CNT_W      matches skipped before firing
//  iResume     in   1          pulse: leave HALT
//  iStep       in   1          pulse: execute exactly one event, then halt
//  oBreak      out  1          1 = CPU clock frozen
//  oHitVec     out  N_BP       channels that fired on the halting event
//  oHitIdx     out  4          lowest-index fired channel
//  oStepHalt   out  1          halt caused by single-step
//  oHaltPC     out  ADDR_W     iPC of the halting event
//  oState      out  2          FSM state (monitoring)
// BEHAVIOUR
//  Reset: all channels mode=off, counters 0; FSM=RUN; all outputs 0.
//  Match(ch): mode!=off & iEvValid & ((sel ^ cfgAddr) & cfgMask)==0, sel=iPC for 01, iDAddress for 10/11;
//   10 also needs iDReadEn, 11 needs iDWriteEn.
//  Counter: on match, if cnt==0 the channel fires, else cnt<=cnt-1. Config write loads cnt<=iCfgCount.
//  FSM RUN: any fire -> HALT; oBreak, oHitVec, oHitIdx, oHaltPC registered (latency 1 cycle from iEvValid).
//  Fired channels reload cnt<=cfgCount on firing; non-fired matching channels still decrement in the same event.
//  HALT: iEvValid ignored; iResume -> RUN, oBreak=0 next cycle; iStep -> STEP, oBreak=0 next cycle.
//  iResume & iStep same cycle: step wins.
//  STEP: next iEvValid -> HALT; oStepHalt=1, oHitVec=real fires of that event (may be 0), oHaltPC latched.
//  oHitVec/oHitIdx/oStepHalt hold until next halt; cleared on leaving HALT.
//  Config write same cycle as an event: event uses old config; new config visible next cycle.
//  Config write allowed in any state; does not change FSM state.
//  iResume/iStep in RUN: ignored. iRST mid-halt: immediate return to reset values next edge.
//  Mask of 0 matches every qualified event; full mask = exact compare.
// CONFIGURATION
//  BP_TRACE_EN defined: 8-entry circular buffer of iPC, written on every iEvValid in RUN/STEP;
//   extra ports iTraceIdx(in,3; 0 = newest) and oTracePC(out,ADDR_W, combinational read);
//   buffer is frozen in HALT and cleared to 0 on reset.
//  BP_TRACE_EN undefined: ports absent, no trace storage.
// STRUCTURE
//  Package bp_pkg: mode constants (BP_OFF/BP_PC/BP_DRD/BP_DWR), FSM encoding (RUN=0, HALT=1, STEP=2).
//  Sub-module bp_channel: config regs, masked comparator, skip counter; outputs match/fire.
//  Generated N_BP times; top holds FSM, priority encoder, latches and optional trace buffer.
// TESTING
//  1 ch0 PC 0x400010 mask all-ones cnt 0; events PC 0x400000..0x400010 step 4 -> oBreak after 5th event, oHaltPC=0x400010, oHitVec=0001.
//  2 ch1 data-write 0x1000 mask ~0xFF cnt 2; writes to 0x1004 x3 -> halt on 3rd write only; reads to 0x1004 never match.
//  3 in HALT pulse iStep -> exactly one event passes, then HALT with oStepHalt=1, oHaltPC=next PC.
//  4 ch0 and ch2 both match the same PC -> oHitVec=0101, oHitIdx=0; iResume & iStep same cycle -> STEP.
//  5 iCfgWe reprogramming ch0 in the same cycle as a matching event -> old config fires; next event uses new config.
//  6 iRST asserted while HALT -> next edge oBreak=0, oState=RUN, all channels off; BP_TRACE_EN: oTracePC(0)=last PC before halt.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the breakpoint unit: channel compare modes, FSM encoding
// and the lowest-set-bit helper used to report the winning channel.
package bp_pkg;

    typedef enum logic [1:0] {
        BP_OFF = 2'b00,
        BP_PC  = 2'b01,
        BP_DRD = 2'b10,
        BP_DWR = 2'b11
    } bp_mode_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } bp_state_e;

    // Callers zero-extend their hit vector to 16 bits; an empty vector reports 0.
    function automatic logic [3:0] lowest_index(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bp_channel.sv
// One breakpoint/watchpoint channel: holds its configuration, performs the
// masked address compare and runs the skip counter that gates firing.
module bp_channel
    import bp_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ev_valid,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] daddr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_mode,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [ADDR_W-1:0] cfg_mask,
    input  logic [CNT_W-1:0]  cfg_count,
    output logic              fire
);

    bp_mode_e          mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] sel;
    logic              qual;
    logic              match;

    always_comb begin
        sel   = (mode_q == BP_PC) ? pc : daddr;
        case (mode_q)
            BP_PC:   qual = 1'b1;
            BP_DRD:  qual = rd_en;
            BP_DWR:  qual = wr_en;
            default: qual = 1'b0;
        endcase
        match = ev_valid && qual && (((sel ^ addr_q) & mask_q) == '0);
        fire  = match && (cnt_q == '0);

        mode_d  = mode_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        // The compare above always sees the old config; a write only lands at the edge.
        if (cfg_we) begin
            mode_d  = bp_mode_e'(cfg_mode);
            addr_d  = cfg_addr;
            mask_d  = cfg_mask;
            count_d = cfg_count;
            cnt_d   = cfg_count;
        end else if (match) begin
            cnt_d = fire ? count_q : cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= BP_OFF;
            addr_q  <= '0;
            mask_q  <= '0;
            count_q <= '0;
            cnt_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/breakpoint_unit.sv
// Multi-channel breakpoint unit: N_BP comparator channels, halt/step FSM and
// registered halt reporting. Define BP_TRACE_EN to add an 8-entry PC trace buffer.
module breakpoint_unit
    import bp_pkg::*;
#(
    parameter int N_BP   = 4,
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iEvValid,
    input  logic [ADDR_W-1:0] iPC,
    input  logic [ADDR_W-1:0] iDAddress,
    input  logic              iDReadEn,
    input  logic              iDWriteEn,
    input  logic              iCfgWe,
    input  logic [3:0]        iCfgIdx,
    input  logic [1:0]        iCfgMode,
    input  logic [ADDR_W-1:0] iCfgAddr,
    input  logic [ADDR_W-1:0] iCfgMask,
    input  logic [CNT_W-1:0]  iCfgCount,
    input  logic              iResume,
    input  logic              iStep,
    output logic              oBreak,
    output logic [N_BP-1:0]   oHitVec,
    output logic [3:0]        oHitIdx,
    output logic              oStepHalt,
    output logic [ADDR_W-1:0] oHaltPC,
    output logic [1:0]        oState
`ifdef BP_TRACE_EN
    ,
    input  logic [2:0]        iTraceIdx,
    output logic [ADDR_W-1:0] oTracePC
`endif
);

    bp_state_e         state_q, state_d;
    logic              break_q, break_d;
    logic [N_BP-1:0]   hit_vec_q, hit_vec_d;
    logic [3:0]        hit_idx_q, hit_idx_d;
    logic              step_halt_q, step_halt_d;
    logic [ADDR_W-1:0] halt_pc_q, halt_pc_d;
    logic [N_BP-1:0]   fire_vec;
    logic              ev_live;

    // Events arriving while halted must not advance skip counters or the trace.
    assign ev_live = iEvValid && (state_q != ST_HALT);

    for (genvar g = 0; g < N_BP; g++) begin : g_ch
        bp_channel #(
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk       (iCLK),
            .rst       (iRST),
            .ev_valid  (ev_live),
            .pc        (iPC),
            .daddr     (iDAddress),
            .rd_en     (iDReadEn),
            .wr_en     (iDWriteEn),
            .cfg_we    (iCfgWe && (iCfgIdx == 4'(g))),
            .cfg_mode  (iCfgMode),
            .cfg_addr  (iCfgAddr),
            .cfg_mask  (iCfgMask),
            .cfg_count (iCfgCount),
            .fire      (fire_vec[g])
        );
    end

    always_comb begin
        state_d     = state_q;
        break_d     = break_q;
        hit_vec_d   = hit_vec_q;
        hit_idx_d   = hit_idx_q;
        step_halt_d = step_halt_q;
        halt_pc_d   = halt_pc_q;
        case (state_q)
            ST_RUN: begin
                if (ev_live && (|fire_vec)) begin
                    state_d     = ST_HALT;
                    break_d     = 1'b1;
                    hit_vec_d   = fire_vec;
                    hit_idx_d   = lowest_index(16'(fire_vec));
                    step_halt_d = 1'b0;
                    halt_pc_d   = iPC;
                end
            end
            ST_STEP: begin
                if (ev_live) begin
                    state_d     = ST_HALT;
                    break_d     = 1'b1;
                    hit_vec_d   = fire_vec;
                    hit_idx_d   = lowest_index(16'(fire_vec));
                    step_halt_d = 1'b1;
                    halt_pc_d   = iPC;
                end
            end
            ST_HALT: begin
                // Step takes priority when both release requests arrive together.
                if (iStep || iResume) begin
                    state_d     = iStep ? ST_STEP : ST_RUN;
                    break_d     = 1'b0;
                    hit_vec_d   = '0;
                    hit_idx_d   = 4'd0;
                    step_halt_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_RUN;
                break_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= ST_RUN;
            break_q     <= 1'b0;
            hit_vec_q   <= '0;
            hit_idx_q   <= 4'd0;
            step_halt_q <= 1'b0;
            halt_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            break_q     <= break_d;
            hit_vec_q   <= hit_vec_d;
            hit_idx_q   <= hit_idx_d;
            step_halt_q <= step_halt_d;
            halt_pc_q   <= halt_pc_d;
        end
    end

    assign oBreak    = break_q;
    assign oHitVec   = hit_vec_q;
    assign oHitIdx   = hit_idx_q;
    assign oStepHalt = step_halt_q;
    assign oHaltPC   = halt_pc_q;
    assign oState    = state_q;

`ifdef BP_TRACE_EN
    logic [ADDR_W-1:0] trace_q [8];
    logic [ADDR_W-1:0] trace_d [8];
    logic [2:0]        wptr_q, wptr_d;

    always_comb begin
        trace_d = trace_q;
        wptr_d  = wptr_q;
        if (ev_live) begin
            trace_d[wptr_q] = iPC;
            wptr_d          = wptr_q + 3'd1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < 8; i++) begin
                trace_q[i] <= '0;
            end
            wptr_q <= 3'd0;
        end else begin
            trace_q <= trace_d;
            wptr_q  <= wptr_d;
        end
    end

    // wptr_q points at the next free slot, so index 0 is the slot just behind it.
    assign oTracePC = trace_q[wptr_q - 3'd1 - iTraceIdx];
`endif

endmodule

// File: tb/tb_breakpoint_unit.sv
// Directed bench for breakpoint_unit: PC/data breakpoints, skip counts, step,
// resume, config-write timing and reset while halted (trace checks with BP_TRACE_EN).
module tb_breakpoint_unit;
    import bp_pkg::*;

    localparam int N_BP   = 4;
    localparam int ADDR_W = 64;
    localparam int CNT_W  = 8;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic              iCLK = 1'b0;
    logic              iRST;
    logic              iEvValid;
    logic [ADDR_W-1:0] iPC;
    logic [ADDR_W-1:0] iDAddress;
    logic              iDReadEn;
    logic              iDWriteEn;
    logic              iCfgWe;
    logic [3:0]        iCfgIdx;
    logic [1:0]        iCfgMode;
    logic [ADDR_W-1:0] iCfgAddr;
    logic [ADDR_W-1:0] iCfgMask;
    logic [CNT_W-1:0]  iCfgCount;
    logic              iResume;
    logic              iStep;
    logic              oBreak;
    logic [N_BP-1:0]   oHitVec;
    logic [3:0]        oHitIdx;
    logic              oStepHalt;
    logic [ADDR_W-1:0] oHaltPC;
    logic [1:0]        oState;
`ifdef BP_TRACE_EN
    logic [2:0]        iTraceIdx;
    logic [ADDR_W-1:0] oTracePC;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 iCLK = ~iCLK;

    breakpoint_unit #(
        .N_BP   (N_BP),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iEvValid  (iEvValid),
        .iPC       (iPC),
        .iDAddress (iDAddress),
        .iDReadEn  (iDReadEn),
        .iDWriteEn (iDWriteEn),
        .iCfgWe    (iCfgWe),
        .iCfgIdx   (iCfgIdx),
        .iCfgMode  (iCfgMode),
        .iCfgAddr  (iCfgAddr),
        .iCfgMask  (iCfgMask),
        .iCfgCount (iCfgCount),
        .iResume   (iResume),
        .iStep     (iStep),
        .oBreak    (oBreak),
        .oHitVec   (oHitVec),
        .oHitIdx   (oHitIdx),
        .oStepHalt (oStepHalt),
        .oHaltPC   (oHaltPC),
        .oState    (oState)
`ifdef BP_TRACE_EN
        ,
        .iTraceIdx (iTraceIdx),
        .oTracePC  (oTracePC)
`endif
    );

    // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [63:0] pc, input logic [63:0] daddr,
                                 input logic rd, input logic wr);
        iEvValid  = 1'b1;
        iPC       = pc;
        iDAddress = daddr;
        iDReadEn  = rd;
        iDWriteEn = wr;
        tick();
        iEvValid  = 1'b0;
        iDReadEn  = 1'b0;
        iDWriteEn = 1'b0;
    endtask

    task automatic cfgWrite(input logic [3:0] idx, input logic [1:0] mode,
                            input logic [63:0] addr, input logic [63:0] mask,
                            input logic [7:0] cnt);
        iCfgWe    = 1'b1;
        iCfgIdx   = idx;
        iCfgMode  = mode;
        iCfgAddr  = addr;
        iCfgMask  = mask;
        iCfgCount = cnt;
        tick();
        iCfgWe    = 1'b0;
    endtask

    task automatic pulseCtl(input logic resume, input logic step);
        iResume = resume;
        iStep   = step;
        tick();
        iResume = 1'b0;
        iStep   = 1'b0;
    endtask

    initial begin
        iRST = 1'b1; iEvValid = 1'b0; iPC = '0; iDAddress = '0;
        iDReadEn = 1'b0; iDWriteEn = 1'b0; iCfgWe = 1'b0; iCfgIdx = '0;
        iCfgMode = '0; iCfgAddr = '0; iCfgMask = '0; iCfgCount = '0;
        iResume = 1'b0; iStep = 1'b0;
`ifdef BP_TRACE_EN
        iTraceIdx = 3'd0;
`endif
        tick();
        tick();
        iRST = 1'b0;
        checkOutput("reset_break", 64'(oBreak), 64'd0);
        checkOutput("reset_state", 64'(oState), 64'd0);
        checkOutput("reset_hitvec", 64'(oHitVec), 64'd0);
        checkOutput("reset_haltpc", oHaltPC, 64'd0);

        // PC breakpoint hit on the fifth sequential fetch
        cfgWrite(4'd0, BP_PC, 64'h40_0010, ALL_ONES, 8'd0);
        applyStimulus(64'h40_0000, 64'h0, 1'b0, 1'b0);
        applyStimulus(64'h40_0004, 64'h0, 1'b0, 1'b0);
        applyStimulus(64'h40_0008, 64'h0, 1'b0, 1'b0);
        applyStimulus(64'h40_000C, 64'h0, 1'b0, 1'b0);
        checkOutput("pc_no_break_early", 64'(oBreak), 64'd0);
        applyStimulus(64'h40_0010, 64'h0, 1'b0, 1'b0);
        checkOutput("pc_break", 64'(oBreak), 64'd1);
        checkOutput("pc_state_halt", 64'(oState), 64'd1);
        checkOutput("pc_haltpc", oHaltPC, 64'h40_0010);
        checkOutput("pc_hitvec", 64'(oHitVec), 64'h1);
        checkOutput("pc_hitidx", 64'(oHitIdx), 64'd0);
        checkOutput("pc_stephalt", 64'(oStepHalt), 64'd0);

        // Events while halted are ignored
        applyStimulus(64'h40_0000, 64'h0, 1'b0, 1'b0);
        checkOutput("halt_ignore_state", 64'(oState), 64'd1);
        checkOutput("halt_ignore_pc", oHaltPC, 64'h40_0010);

        // Single step: one event passes then halt again
        pulseCtl(1'b0, 1'b1);
        checkOutput("step_state", 64'(oState), 64'd2);
        checkOutput("step_break_low", 64'(oBreak), 64'd0);
        checkOutput("step_hitvec_clr", 64'(oHitVec), 64'd0);
        applyStimulus(64'h40_0014, 64'h0, 1'b0, 1'b0);
        checkOutput("step_break", 64'(oBreak), 64'd1);
        checkOutput("step_state_halt", 64'(oState), 64'd1);
        checkOutput("step_stephalt", 64'(oStepHalt), 64'd1);
        checkOutput("step_haltpc", oHaltPC, 64'h40_0014);
        checkOutput("step_hitvec", 64'(oHitVec), 64'd0);
        pulseCtl(1'b1, 1'b0);
        checkOutput("resume_state", 64'(oState), 64'd0);
        checkOutput("resume_break", 64'(oBreak), 64'd0);
        checkOutput("resume_stephalt_clr", 64'(oStepHalt), 64'd0);

        // Data-write watchpoint with skip count 2; reads must not count
        cfgWrite(4'd0, BP_OFF, 64'h0, 64'h0, 8'd0);
        cfgWrite(4'd1, BP_DWR, 64'h1000, 64'hFFFF_FFFF_FFFF_FF00, 8'd2);
        applyStimulus(64'h50_0000, 64'h1004, 1'b1, 1'b0);
        applyStimulus(64'h50_0004, 64'h1004, 1'b1, 1'b0);
        applyStimulus(64'h50_0008, 64'h1004, 1'b1, 1'b0);
        checkOutput("dwr_reads_no_break", 64'(oBreak), 64'd0);
        applyStimulus(64'h50_000C, 64'h1004, 1'b0, 1'b1);
        checkOutput("dwr_write1", 64'(oBreak), 64'd0);
        applyStimulus(64'h50_0010, 64'h1004, 1'b0, 1'b1);
        checkOutput("dwr_write2", 64'(oBreak), 64'd0);
        applyStimulus(64'h50_0014, 64'h1004, 1'b0, 1'b1);
        checkOutput("dwr_write3_break", 64'(oBreak), 64'd1);
        checkOutput("dwr_hitvec", 64'(oHitVec), 64'h2);
        checkOutput("dwr_hitidx", 64'(oHitIdx), 64'd1);
        checkOutput("dwr_haltpc", oHaltPC, 64'h50_0014);
        pulseCtl(1'b1, 1'b0);

        // Two channels hit the same PC; ch2 has mask 0 (matches anything)
        cfgWrite(4'd1, BP_OFF, 64'h0, 64'h0, 8'd0);
        cfgWrite(4'd0, BP_PC, 64'h60_0000, ALL_ONES, 8'd0);
        cfgWrite(4'd2, BP_PC, 64'hDEAD_0000, 64'h0, 8'd0);
        applyStimulus(64'h60_0000, 64'h0, 1'b0, 1'b0);
        checkOutput("dual_break", 64'(oBreak), 64'd1);
        checkOutput("dual_hitvec", 64'(oHitVec), 64'h5);
        checkOutput("dual_hitidx", 64'(oHitIdx), 64'd0);
        pulseCtl(1'b1, 1'b1);
        checkOutput("resume_step_state", 64'(oState), 64'd2);
        checkOutput("resume_step_break", 64'(oBreak), 64'd0);
        applyStimulus(64'h60_0004, 64'h0, 1'b0, 1'b0);
        checkOutput("mask0_step_hitvec", 64'(oHitVec), 64'h4);
        checkOutput("mask0_step_hitidx", 64'(oHitIdx), 64'd2);
        checkOutput("mask0_step_stephalt", 64'(oStepHalt), 64'd1);
        pulseCtl(1'b1, 1'b0);
        cfgWrite(4'd2, BP_OFF, 64'h0, 64'h0, 8'd0);

        // Reprogram ch0 in the same cycle as an event matching its old address
        iCfgWe = 1'b1; iCfgIdx = 4'd0; iCfgMode = BP_PC;
        iCfgAddr = 64'h70_0000; iCfgMask = ALL_ONES; iCfgCount = 8'd0;
        applyStimulus(64'h60_0000, 64'h0, 1'b0, 1'b0);
        iCfgWe = 1'b0;
        checkOutput("cfg_old_fires", 64'(oBreak), 64'd1);
        checkOutput("cfg_old_haltpc", oHaltPC, 64'h60_0000);
        pulseCtl(1'b1, 1'b0);
        pulseCtl(1'b0, 1'b1);
        checkOutput("step_in_run_ignored", 64'(oState), 64'd0);
        applyStimulus(64'h60_0000, 64'h0, 1'b0, 1'b0);
        checkOutput("cfg_old_addr_gone", 64'(oBreak), 64'd0);
        applyStimulus(64'h70_0000, 64'h0, 1'b0, 1'b0);
        checkOutput("cfg_new_fires", 64'(oBreak), 64'd1);
        checkOutput("cfg_new_haltpc", oHaltPC, 64'h70_0000);
        applyStimulus(64'h12_3456, 64'h0, 1'b0, 1'b0);
`ifdef BP_TRACE_EN
        iTraceIdx = 3'd0;
        #1;
        checkOutput("trace_newest", oTracePC, 64'h70_0000);
        iTraceIdx = 3'd1;
        #1;
        checkOutput("trace_prev", oTracePC, 64'h60_0000);
        iTraceIdx = 3'd0;
`endif

        // Reset while halted returns everything to idle
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        checkOutput("rst_halt_break", 64'(oBreak), 64'd0);
        checkOutput("rst_halt_state", 64'(oState), 64'd0);
        checkOutput("rst_halt_hitvec", 64'(oHitVec), 64'd0);
        checkOutput("rst_halt_haltpc", oHaltPC, 64'd0);
`ifdef BP_TRACE_EN
        #1;
        checkOutput("rst_trace_clear", oTracePC, 64'd0);
`endif
        applyStimulus(64'h70_0000, 64'h0, 1'b0, 1'b0);
        checkOutput("rst_channels_off", 64'(oBreak), 64'd0);

        // Out-of-range channel index is ignored
        cfgWrite(4'd4, BP_PC, 64'h0, 64'h0, 8'd0);
        applyStimulus(64'h80_0000, 64'h0, 1'b0, 1'b0);
        checkOutput("cfg_idx_oob", 64'(oBreak), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
